wb_regfile: RTL and testbench

Writeback-stage register file for the five-stage pipeline: consumes the MEM/WB pipeline register outputs, selects the writeback value (ALU result or load data), commits it to a 32×32-bit integer register file, and serves the two decode-stage read ports. Sits at the downstream end of the MEM/WB interface and provides the architectural register state read by ID. Also keeps a wrapping count of committed register writes for debug/performance observation.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/wb_regfile_core.sv | 37 +++
 rtl/wb_regfile.sv | 71 +++++++
 tb/tb_wb_regfile.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline constants for the integer datapath: widths, register
// indices and the writeback-select encoding used by MEM/WB consumers.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // MemtoReg encoding: which MEM/WB bus feeds the register file.
  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_MEM = 1'b1;

  typedef enum logic {
    WB_ALU = WB_SEL_ALU,
    WB_MEM = WB_SEL_MEM
  } wb_sel_e;

  function automatic logic is_commit(input logic we, input logic [REG_ADDR_W-1:0] rd);
    return we && (rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_regfile_core.sv
// Architectural integer register storage: one write port with the x0 guard
// and two combinational read ports that always return zero for x0.
module regfile_core
  import cpu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  we_i,
  input  logic [REG_ADDR_W-1:0] waddr_i,
  input  logic [XLEN-1:0]       wdata_i,
  input  logic [REG_ADDR_W-1:0] raddr1_i,
  input  logic [REG_ADDR_W-1:0] raddr2_i,
  output logic [XLEN-1:0]       rdata1_o,
  output logic [XLEN-1:0]       rdata2_o
);

  logic [XLEN-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (is_commit(we_i, waddr_i)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // x0 is masked on read as well, so it reads zero even if storage were disturbed.
  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    if (raddr1_i != REG_ZERO) rdata1_o = regs_q[raddr1_i];
    if (raddr2_i != REG_ZERO) rdata2_o = regs_q[raddr2_i];
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects ALU/load result, commits it to the register file,
// serves the ID read ports and counts committed writes. Optional WB_BYPASS_EN.
module wb_regfile
  import cpu_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  RegWrite_i,
  input  logic                  MemtoReg_i,
  input  logic [XLEN-1:0]       ALUResult_i,
  input  logic [XLEN-1:0]       RDdata_i,
  input  logic [REG_ADDR_W-1:0] Instruction4_i,
  input  logic [REG_ADDR_W-1:0] RS1addr_i,
  input  logic [REG_ADDR_W-1:0] RS2addr_i,
  output logic [XLEN-1:0]       RS1data_o,
  output logic [XLEN-1:0]       RS2data_o,
  output logic [XLEN-1:0]       WBdata_o,
  output logic [31:0]           WBcount_o
);

  logic [XLEN-1:0] wbData;
  logic            commit;
  logic [XLEN-1:0] rs1Stored;
  logic [XLEN-1:0] rs2Stored;
  logic [31:0]     count_q;
  logic [31:0]     count_d;
  wb_sel_e         wbSel;

  assign wbSel    = wb_sel_e'(MemtoReg_i);
  assign wbData   = (wbSel == WB_MEM) ? RDdata_i : ALUResult_i;
  assign WBdata_o = wbData;
  assign commit   = is_commit(RegWrite_i, Instruction4_i);

  regfile_core u_core (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .we_i     (RegWrite_i),
    .waddr_i  (Instruction4_i),
    .wdata_i  (wbData),
    .raddr1_i (RS1addr_i),
    .raddr2_i (RS2addr_i),
    .rdata1_o (rs1Stored),
    .rdata2_o (rs2Stored)
  );

`ifdef WB_BYPASS_EN
  // Write-first: a read of the register being committed sees the new value now.
  always_comb begin
    RS1data_o = rs1Stored;
    RS2data_o = rs2Stored;
    if (commit && (RS1addr_i == Instruction4_i)) RS1data_o = wbData;
    if (commit && (RS2addr_i == Instruction4_i)) RS2data_o = wbData;
  end
`else
  assign RS1data_o = rs1Stored;
  assign RS2data_o = rs2Stored;
`endif

  assign count_d = commit ? (count_q + 32'd1) : count_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign WBcount_o = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; bypass expectations follow
// WB_BYPASS_EN when the bench is built with it.
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        RegWrite;
  logic        MemtoReg;
  logic [31:0] ALUResult;
  logic [31:0] RDdata;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] RS1data;
  logic [31:0] RS2data;
  logic [31:0] WBdata;
  logic [31:0] WBcount;

  int checks = 0;
  int errors = 0;

  wb_regfile dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .RegWrite_i     (RegWrite),
    .MemtoReg_i     (MemtoReg),
    .ALUResult_i    (ALUResult),
    .RDdata_i       (RDdata),
    .Instruction4_i (rd),
    .RS1addr_i      (rs1),
    .RS2addr_i      (rs2),
    .RS1data_o      (RS1data),
    .RS2data_o      (RS2data),
    .WBdata_o       (WBdata),
    .WBcount_o      (WBcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [4:0] d);
    RegWrite  = we;
    MemtoReg  = m2r;
    ALUResult = alu;
    RDdata    = mem;
    rd        = d;
  endtask

  task automatic test_reset;
    rs1 = 5'd5; rs2 = 5'd31;
    #1;
    check32("reset_rs1", RS1data, 32'h0);
    check32("reset_rs2", RS2data, 32'h0);
    check32("reset_count", WBcount, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu_writeback;
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0000_1234, 32'hAAAA_5555, 5'd5);
    rs1 = 5'd5;
    #1;
    check32("alu_wbdata", WBdata, 32'h0000_1234);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check32("alu_rs1", RS1data, 32'h0000_1234);
    check32("alu_count", WBcount, 32'd1);
  endtask

  task automatic test_load_writeback;
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h0000_0001, 32'hDEAD_BEEF, 5'd31);
    #1;
    check32("load_wbdata", WBdata, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rs1 = 5'd5; rs2 = 5'd31;
    #1;
    check32("load_rs2", RS2data, 32'hDEAD_BEEF);
    check32("load_rs1_keep", RS1data, 32'h0000_1234);
    check32("load_count", WBcount, 32'd2);
  endtask

  task automatic test_x0_and_disabled;
    @(negedge clk);
    drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0000_0077, 32'h0, 5'd7);
    #1;
    check32("disabled_wbdata", WBdata, 32'h0000_0077);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rs1 = 5'd0; rs2 = 5'd7;
    #1;
    check32("x0_read", RS1data, 32'h0);
    check32("disabled_x7", RS2data, 32'h0);
    check32("x0_count", WBcount, 32'd2);
  endtask

  task automatic test_bypass;
    logic [31:0] sameCycle;
`ifdef WB_BYPASS_EN
    sameCycle = 32'hCAFE_0001;
`else
    sameCycle = 32'h0;
`endif
    @(negedge clk);
    drive(1'b1, 1'b0, 32'hCAFE_0001, 32'h0, 5'd10);
    rs1 = 5'd10; rs2 = 5'd10;
    #1;
    check32("bypass_rs1_same", RS1data, sameCycle);
    check32("bypass_rs2_same", RS2data, sameCycle);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check32("bypass_rs1_next", RS1data, 32'hCAFE_0001);
    check32("bypass_rs2_next", RS2data, 32'hCAFE_0001);
    check32("bypass_count", WBcount, 32'd3);
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0000_0011, 32'h0, 5'd1);
    @(negedge clk);
    drive(1'b1, 1'b1, 32'h0, 32'h0000_0022, 5'd2);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0000_0033, 32'h0, 5'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rs1 = 5'd1; rs2 = 5'd2;
    #1;
    check32("b2b_r1_overwrite", RS1data, 32'h0000_0033);
    check32("b2b_r2", RS2data, 32'h0000_0022);
    check32("b2b_count", WBcount, 32'd6);
  endtask

  task automatic test_counter_wrap;
    @(negedge clk);
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    #1;
    check32("wrap_preload", WBcount, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 32'h0000_0003, 32'h0, 5'd3);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rs1 = 5'd3;
    #1;
    check32("wrap_count", WBcount, 32'h0);
    check32("wrap_r3", RS1data, 32'h0000_0003);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0000_0044, 32'h0, 5'd4);
    rs1 = 5'd1; rs2 = 5'd31;
    #2;
    rst_n = 1'b0;
    #1;
    check32("midreset_rs1", RS1data, 32'h0);
    check32("midreset_rs2", RS2data, 32'h0);
    check32("midreset_count", WBcount, 32'h0);
    check32("midreset_wbdata", WBdata, 32'h0000_0044);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rst_n = 1'b1;
    rs1 = 5'd4; rs2 = 5'd10;
    #1;
    check32("midreset_lost_r4", RS1data, 32'h0);
    check32("midreset_r10", RS2data, 32'h0);
    check32("midreset_count_after", WBcount, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    rs1 = 5'd0; rs2 = 5'd0;
    test_reset;
    test_alu_writeback;
    test_load_writeback;
    test_x0_and_disabled;
    test_bypass;
    test_back_to_back;
    test_counter_wrap;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
